// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and memory bus bundle for the data memory arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Port 0: CPU load/store unit
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_err;

  // Port 1: debug/DMA loader
  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_err;

  // Memory side
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_rdata, m1_err,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  // Requesters plus memory view
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata, m0_err,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata, m1_err,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter and access sequencer for the data memory
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Highest word-aligned byte address inside the memory
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 4);

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              cmd_id_q, cmd_id_d;
  logic              cmd_we_q, cmd_we_d;
  logic              cmd_legal_q, cmd_legal_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;
  logic              m0_err_q, m0_err_d;
  logic              m1_err_q, m1_err_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  logic              win;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_legal;
  logic [DATA_W-1:0] rd_word;

  // Round-robin pick: on contention the port not granted last time wins
  always_comb begin
    win       = (bus.m0_req && bus.m1_req) ? ~last_q : bus.m1_req;
    win_we    = win ? bus.m1_we    : bus.m0_we;
    win_addr  = win ? bus.m1_addr  : bus.m0_addr;
    win_wdata = win ? bus.m1_wdata : bus.m0_wdata;
    win_legal = (win_addr[1:0] == 2'b00) && (win_addr <= MAX_ADDR);
  end

  // Next-state and registered-output computation for the IDLE/ACCESS/RESP sequence
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cmd_id_d    = cmd_id_q;
    cmd_we_d    = cmd_we_q;
    cmd_legal_d = cmd_legal_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    busy_d      = busy_q;
    mem_we_d    = 1'b0;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;
    m0_err_d    = 1'b0;
    m1_err_d    = 1'b0;
    m0_rdata_d  = '0;
    m1_rdata_d  = '0;
    // Writes and rejected accesses hand back zero
    rd_word     = (cmd_legal_q && !cmd_we_q) ? bus.mem_rdata : '0;

    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          state_d     = ACCESS;
          last_d      = win;
          cmd_id_d    = win;
          cmd_we_d    = win_we;
          cmd_legal_d = win_legal;
          cmd_addr_d  = win_addr;
          cmd_wdata_d = win_wdata;
          mem_we_d    = win_we && win_legal;
          busy_d      = 1'b1;
        end
      end
      ACCESS: begin
        state_d = RESP;
        busy_d  = 1'b1;
        if (cmd_id_q) begin
          m1_ack_d   = 1'b1;
          m1_err_d   = ~cmd_legal_q;
          m1_rdata_d = rd_word;
        end else begin
          m0_ack_d   = 1'b1;
          m0_err_d   = ~cmd_legal_q;
          m0_rdata_d = rd_word;
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      cmd_id_q    <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_legal_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m0_err_q    <= 1'b0;
      m1_err_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cmd_id_q    <= cmd_id_d;
      cmd_we_q    <= cmd_we_d;
      cmd_legal_q <= cmd_legal_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
      m0_err_q    <= m0_err_d;
      m1_err_q    <= m1_err_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  // Memory address and write data hold the last latched command between accesses
  assign bus.mem_addr  = cmd_addr_q;
  assign bus.mem_wdata = cmd_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.m0_ack    = m0_ack_q;
  assign bus.m1_ack    = m1_ack_q;
  assign bus.m0_err    = m0_err_q;
  assign bus.m1_err    = m1_err_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rdata  = m1_rdata_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(1024)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Data memory model: combinational read, write on rising edge
  logic [31:0] mem [0:255];
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;

  // Event counters sampled on the falling edge
  int we_cnt = 0, ack0_cnt = 0, ack1_cnt = 0;
  always @(negedge clk) begin
    if (bus.mem_we) we_cnt++;
    if (bus.m0_ack) ack0_cnt++;
    if (bus.m1_ack) ack1_cnt++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input int port, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end else begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end
  endtask

  // One access: lat counts falling edges after the sampling edge until ack (-1 on timeout)
  task automatic do_access(input int port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic err, output int lat, output logic we_seen,
                           output logic [31:0] maddr_seen);
    @(negedge clk);
    drive(port, 1'b1, we, addr, wdata);
    @(posedge clk);
    lat = -1; rdata = '0; err = 1'b0; we_seen = 1'b0; maddr_seen = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        we_seen = bus.mem_we;
        maddr_seen = bus.mem_addr;
      end
      if ((port == 0 && bus.m0_ack) || (port == 1 && bus.m1_ack)) begin
        lat = k;
        rdata = (port == 0) ? bus.m0_rdata : bus.m1_rdata;
        err = (port == 0) ? bus.m0_err : bus.m1_err;
        break;
      end
    end
    drive(port, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
  endtask

  logic [31:0] rd, maddr;
  logic        er, wes;
  int          lat, w0, a0, a1;

  // Contention bookkeeping
  int          ack_t [4];
  int          ack_p [4];
  logic [31:0] ack_v [4];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset state
    @(negedge clk); #1;
    check_eq("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
    check_eq("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check_eq("rst_acks", {30'b0, bus.m1_ack, bus.m0_ack}, 32'h0);
    check_eq("rst_rdata", bus.m0_rdata | bus.m1_rdata, 32'h0);
    check_eq("rst_errs", {30'b0, bus.m1_err, bus.m0_err}, 32'h0);
    check_eq("rst_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write then read at 0x8
    #1 w0 = we_cnt;
    do_access(0, 1'b1, 32'h8, 32'hDEADBEEF, rd, er, lat, wes, maddr);
    check_eq("wr8_lat", lat, 32'd2);
    check_eq("wr8_we", {31'b0, wes}, 32'h1);
    check_eq("wr8_addr", maddr, 32'h8);
    check_eq("wr8_err", {31'b0, er}, 32'h0);
    check_eq("wr8_we_cycles", we_cnt - w0, 32'd1);
    do_access(0, 1'b0, 32'h8, 32'h0, rd, er, lat, wes, maddr);
    check_eq("rd8_lat", lat, 32'd2);
    check_eq("rd8_data", rd, 32'hDEADBEEF);
    check_eq("rd8_err", {31'b0, er}, 32'h0);
    check_eq("rd8_we", {31'b0, wes}, 32'h0);

    // Reset in the middle of a write to 0x10
    do_access(0, 1'b1, 32'h10, 32'h12345678, rd, er, lat, wes, maddr);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h10, 32'hCAFEF00D);
    @(posedge clk); #2;
    check_eq("rstmid_in_access", {31'b0, bus.mem_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_mem_we", {31'b0, bus.mem_we}, 32'h0);
    check_eq("rstmid_mem_addr", bus.mem_addr, 32'h0);
    check_eq("rstmid_mem_wdata", bus.mem_wdata, 32'h0);
    check_eq("rstmid_busy", {31'b0, busy}, 32'h0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    a0 = ack0_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check_eq("rstmid_no_ack", ack0_cnt - a0, 32'd0);
    do_access(0, 1'b0, 32'h10, 32'h0, rd, er, lat, wes, maddr);
    check_eq("rstmid_word_kept", rd, 32'h12345678);

    // Contention: preload 0x0 and 0x4, then both ports read continuously
    do_access(0, 1'b1, 32'h0, 32'hA0A0A0A0, rd, er, lat, wes, maddr);
    do_access(1, 1'b1, 32'h4, 32'hB1B1B1B1, rd, er, lat, wes, maddr);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h4, 32'h0);
    begin
      int t = 0;
      int seen = 0;
      while (seen < 4 && t < 30) begin
        @(negedge clk);
        t++;
        if (bus.m0_ack && seen < 4) begin
          ack_t[seen] = t; ack_p[seen] = 0; ack_v[seen] = bus.m0_rdata; seen++;
        end
        if (bus.m1_ack && seen < 4) begin
          ack_t[seen] = t; ack_p[seen] = 1; ack_v[seen] = bus.m1_rdata; seen++;
        end
      end
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      check_eq("cont_count", seen, 32'd4);
    end
    check_eq("cont_first_t", ack_t[0], 32'd2);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("cont_port%0d", i), ack_p[i], (i % 2 == 0) ? 32'd0 : 32'd1);
      check_eq($sformatf("cont_data%0d", i), ack_v[i],
               (i % 2 == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1);
      if (i > 0) check_eq($sformatf("cont_gap%0d", i), ack_t[i] - ack_t[i-1], 32'd3);
    end
    #1;

    // Illegal accesses from port 1
    w0 = we_cnt;
    do_access(1, 1'b1, 32'h6, 32'h55555555, rd, er, lat, wes, maddr);
    check_eq("ill_mis_err", {31'b0, er}, 32'h1);
    check_eq("ill_mis_rdata", rd, 32'h0);
    check_eq("ill_mis_lat", lat, 32'd2);
    do_access(1, 1'b1, 32'h3FE, 32'h66666666, rd, er, lat, wes, maddr);
    check_eq("ill_oor_err", {31'b0, er}, 32'h1);
    check_eq("ill_oor_rdata", rd, 32'h0);
    do_access(1, 1'b0, 32'h400, 32'h0, rd, er, lat, wes, maddr);
    check_eq("ill_rd400_err", {31'b0, er}, 32'h1);
    check_eq("ill_rd400_rdata", rd, 32'h0);
    check_eq("ill_no_we", we_cnt - w0, 32'd0);

    // Boundary word at 0x3FC
    do_access(0, 1'b1, 32'h3FC, 32'h11223344, rd, er, lat, wes, maddr);
    check_eq("bnd_wr_err", {31'b0, er}, 32'h0);
    check_eq("bnd_wr_we", {31'b0, wes}, 32'h1);
    do_access(0, 1'b0, 32'h3FC, 32'h0, rd, er, lat, wes, maddr);
    check_eq("bnd_rd_err", {31'b0, er}, 32'h0);
    check_eq("bnd_rd_data", rd, 32'h11223344);

    // Early request drop by port 1
    a1 = ack1_cnt;
    rd = '0;
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'h8, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.m1_ack) rd = bus.m1_rdata;
    end
    #1;
    check_eq("drop_ack_once", ack1_cnt - a1, 32'd1);
    check_eq("drop_rdata", rd, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the byte-addressed, big-endian, 32-bit-word data memory. It sits between the memory and two masters: port 0 is the CPU load/store unit and port 1 is the debug/DMA loader. It grants one word access at a time with round-robin fairness and drives the memory's address, write-data and write-enable inputs. It rejects misaligned and out-of-range accesses before they reach the memory.

## Interface
- ADDR_W, 32, address width of requesters and memory
- DATA_W, 32, word width
- MEM_BYTES, 1024, memory size in bytes; highest legal word address is MEM_BYTES-4
- clk  input  1  rising-edge clock, shared with the data memory
- rst_n  input  1  asynchronous, active-low reset
- m0_req, m1_req  input  1  request; held high until the matching ack
- m0_we, m1_we  input  1  1 = write, 0 = read
- m0_addr, m1_addr  input  ADDR_W  byte address
- m0_wdata, m1_wdata  input  DATA_W  write word
- m0_ack, m1_ack  output  1  one-cycle completion pulse
- m0_rdata, m1_rdata  output  DATA_W  read word; valid while ack is high
- m0_err, m1_err  output  1  access rejected; valid while ack is high
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write word
- mem_we  output  1  memory write enable
- mem_rdata  input  DATA_W  memory read word, combinational from mem_addr
- busy  output  1  high when the FSM is not in IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, any request:
  - Pick a winner.
  - Latch the winner's id, we, addr, wdata and the legality check into cmd registers.
  - Next state is ACCESS.
- Arbitration:
  - A single requester always wins.
  - If both request, the port not granted last time wins.
  - The last-grant pointer resets to 1, so port 0 wins the first contention.
  - The pointer updates on every grant.
- Legality: an access is illegal if addr[1:0] != 0 or addr > MEM_BYTES-4 (unsigned compare on the full ADDR_W).
- ACCESS (exactly 1 cycle):
  - mem_addr = latched addr.
  - mem_wdata = latched wdata.
  - mem_we = latched we AND legal. The memory writes on the rising edge that ends ACCESS.
  - For a legal read, capture mem_rdata into the rdata register at that edge. Illegal accesses capture 0.
  - Next state is RESP.
- RESP (exactly 1 cycle):
  - The granted port's ack = 1.
  - rdata = captured word (0 for writes and for illegal accesses).
  - err = !legal.
  - The other port's ack, rdata and err = 0.
  - Next state is IDLE.
- Request lifetime:
  - Once latched, a command completes even if the requester drops req early.
  - A requester wanting no further access drops req in the cycle after ack. A req still high in IDLE is a new request.
- Outside ACCESS: mem_we = 0, and mem_addr/mem_wdata hold their last latched values (no glitching to requester inputs).
- Requester inputs are never passed combinationally to the memory. All memory-side outputs come from registers.

## Timing
- Reset (asynchronous, any state):
  - FSM goes to IDLE; last-grant = 1.
  - All outputs are 0: mem_addr, mem_wdata, mem_we, both acks, rdata, err, busy.
  - An in-flight access is abandoned: no ack, no write if reset falls before the ACCESS-ending edge.
- Latency:
  - req sampled high at edge N.
  - ACCESS runs in cycle N..N+1; the write commits at edge N+1.
  - ack is high in cycle N+1..N+2.
  - Each access occupies 3 cycles. Peak throughput is one access per 3 cycles.
- Simultaneous requests in IDLE: one grant. The loser stays pending and is granted in the next IDLE if still requesting.
- Back-to-back contention: with both ports holding req, grants alternate 0,1,0,1, one every 3 cycles.
- Read-after-write on the same address by any port: the later read returns the new data, because the write commits before the next IDLE.
- busy = 1 in ACCESS and RESP.

## Test plan
- Reset: assert rst_n=0 mid-ACCESS of a write to 0x10. Required: all outputs go to 0 immediately; the word at 0x10 is unchanged; no ack follows.
- Single write then read: port 0 writes 0xDEADBEEF to 0x8, then reads 0x8. Required: mem_we high exactly one cycle with mem_addr=0x8. Read ack arrives 2 cycles after the req sample, with m0_rdata=0xDEADBEEF and m0_err=0.
- Contention: both ports hold req continuously, reading 0x0 and 0x4. Required: grant order 0,1,0,1; acks spaced 3 cycles apart; no port starved.
- Illegal accesses: port 1 writes to 0x6 (misaligned) and to 0x3FE (out of range, MEM_BYTES=1024); port 1 reads 0x400. Required: m1_err=1 and m1_rdata=0 on each ack; mem_we never asserted.
- Boundary: port 0 writes 0x11223344 to 0x3FC, then reads it back. Required: legal access, m0_rdata=0x11223344.
- Early req drop: port 1 drops req the cycle after it is sampled. Required: the access still completes and m1_ack pulses once.
